// File: rtl/uart_rx_capture_buffer_if.sv
// Bus bundle for uart_rx_capture_buffer: RX capture inputs, shared read
// port and per-channel status outputs. The master side drives the inputs;
// the slave side is the buffer itself.
interface uart_rx_capture_buffer_if #(
    parameter int G_NB_CHANNEL        = 2,
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_BUFFER_ADDR_WIDTH = 4
);
    localparam int SELW = (G_NB_CHANNEL > 1) ? $clog2(G_NB_CHANNEL) : 1;
    localparam int CW   = G_BUFFER_ADDR_WIDTH + 1;

    logic [G_NB_CHANNEL-1:0]              i_rx_done;
    logic [G_NB_CHANNEL*G_DATA_WIDTH-1:0] i_rx_data;
    logic [G_NB_CHANNEL-1:0]              i_parity_err;
    logic [G_NB_CHANNEL-1:0]              i_clr;
    logic                                 i_rd_req;
    logic [SELW-1:0]                      i_rd_sel;
    logic                                 o_rd_valid;
    logic [G_DATA_WIDTH-1:0]              o_rd_data;
    logic                                 o_rd_perr;
    logic                                 o_rd_err;
    logic [G_NB_CHANNEL*CW-1:0]           o_count;
    logic [G_NB_CHANNEL-1:0]              o_empty;
    logic [G_NB_CHANNEL-1:0]              o_full;
    logic [G_NB_CHANNEL-1:0]              o_overflow;

    modport master (
        output i_rx_done, i_rx_data, i_parity_err, i_clr, i_rd_req, i_rd_sel,
        input  o_rd_valid, o_rd_data, o_rd_perr, o_rd_err,
        input  o_count, o_empty, o_full, o_overflow
    );

    modport slave (
        input  i_rx_done, i_rx_data, i_parity_err, i_clr, i_rd_req, i_rd_sel,
        output o_rd_valid, o_rd_data, o_rd_perr, o_rd_err,
        output o_count, o_empty, o_full, o_overflow
    );
endinterface

// File: rtl/uart_rx_capture_buffer.sv
// Multi-channel UART RX capture buffer: one circular buffer per channel,
// filled on each rising edge of that channel's rx_done, drained through a
// single shared read port with one cycle of read latency.
module uart_rx_capture_buffer #(
    parameter int G_NB_CHANNEL        = 2,
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_BUFFER_ADDR_WIDTH = 4,
    parameter int G_OVERWRITE         = 0
) (
    input logic                     clk,
    input logic                     rst_n,
    uart_rx_capture_buffer_if.slave bus
);
    localparam int N    = G_NB_CHANNEL;
    localparam int W    = G_DATA_WIDTH;
    localparam int AW   = G_BUFFER_ADDR_WIDTH;
    localparam int CW   = AW + 1;
    localparam int D    = 2 ** AW;
    localparam int SELW = (N > 1) ? $clog2(N) : 1;
    localparam int SELN = 2 ** SELW;

    logic [N-1:0]    rx_prev_q;
    logic [AW-1:0]   wptr_q [N];
    logic [AW-1:0]   wptr_d [N];
    logic [AW-1:0]   rptr_q [N];
    logic [AW-1:0]   rptr_d [N];
    logic [CW-1:0]   cnt_q  [N];
    logic [CW-1:0]   cnt_d  [N];
    logic [N-1:0]    ovf_q;
    logic [N-1:0]    ovf_d;
    logic [W:0]      mem_q  [N][D];

    logic [SELN-1:0] sel_map_s;
    logic            sel_ok_s;
    logic [SELW-1:0] sel_idx_s;
    logic [N-1:0]    rise_s;
    logic [N-1:0]    pop_s;
    logic [N-1:0]    full_s;
    logic [N-1:0]    wr_en_s;
    logic [W:0]      wr_word_s [N];

    logic            rd_valid_q, rd_valid_d;
    logic            rd_err_q, rd_err_d;
    logic            rd_perr_q, rd_perr_d;
    logic [W-1:0]    rd_data_q, rd_data_d;

    // Per-channel event decode: rx_done edges, read hits and fullness.
    always_comb begin
        for (int i = 0; i < SELN; i++) begin
            sel_map_s[i] = (i < N) ? 1'b1 : 1'b0;
        end
        sel_ok_s  = sel_map_s[bus.i_rd_sel];
        sel_idx_s = sel_ok_s ? bus.i_rd_sel : {SELW{1'b0}};
        for (int k = 0; k < N; k++) begin
            rise_s[k]    = bus.i_rx_done[k] & ~rx_prev_q[k];
            pop_s[k]     = bus.i_rd_req & sel_ok_s & (sel_idx_s == SELW'(k))
                           & (cnt_q[k] != {CW{1'b0}});
            full_s[k]    = (cnt_q[k] == CW'(D));
            wr_word_s[k] = {bus.i_parity_err[k], bus.i_rx_data[k*W +: W]};
        end
    end

    // Pointer, count and overflow next state; clear beats write and read.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            wptr_d[k]  = wptr_q[k];
            rptr_d[k]  = rptr_q[k];
            cnt_d[k]   = cnt_q[k];
            ovf_d[k]   = ovf_q[k];
            wr_en_s[k] = 1'b0;
            if (bus.i_clr[k]) begin
                wptr_d[k] = {AW{1'b0}};
                rptr_d[k] = {AW{1'b0}};
                cnt_d[k]  = {CW{1'b0}};
                ovf_d[k]  = 1'b0;
            end else if (rise_s[k] && (!full_s[k] || pop_s[k])) begin
                // Normal accepted write, possibly paired with a pop.
                wr_en_s[k] = 1'b1;
                wptr_d[k]  = wptr_q[k] + AW'(1);
                if (pop_s[k]) begin
                    rptr_d[k] = rptr_q[k] + AW'(1);
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end else if (rise_s[k]) begin
                // Full with no pop: flag it, optionally replace the oldest.
                ovf_d[k] = 1'b1;
                if (G_OVERWRITE != 0) begin
                    wr_en_s[k] = 1'b1;
                    wptr_d[k]  = wptr_q[k] + AW'(1);
                    rptr_d[k]  = rptr_q[k] + AW'(1);
                end else begin
                    wr_en_s[k] = 1'b0;
                end
            end else if (pop_s[k]) begin
                rptr_d[k] = rptr_q[k] + AW'(1);
                cnt_d[k]  = cnt_q[k] - CW'(1);
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // Read response: pop the oldest word or flag an empty/invalid/cleared read.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        rd_data_d  = rd_data_q;
        rd_perr_d  = rd_perr_q;
        if (bus.i_rd_req) begin
            if (sel_ok_s && !bus.i_clr[sel_idx_s] && (cnt_q[sel_idx_s] != {CW{1'b0}})) begin
                rd_valid_d             = 1'b1;
                {rd_perr_d, rd_data_d} = mem_q[sel_idx_s][rptr_q[sel_idx_s]];
            end else begin
                rd_err_d = 1'b1;
            end
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // Control state registers; rx_done history resets high to mask a held level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q  <= {N{1'b1}};
            ovf_q      <= {N{1'b0}};
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_perr_q  <= 1'b0;
            rd_data_q  <= {W{1'b0}};
            for (int k = 0; k < N; k++) begin
                wptr_q[k] <= {AW{1'b0}};
                rptr_q[k] <= {AW{1'b0}};
                cnt_q[k]  <= {CW{1'b0}};
            end
        end else begin
            rx_prev_q  <= bus.i_rx_done;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_perr_q  <= rd_perr_d;
            rd_data_q  <= rd_data_d;
            for (int k = 0; k < N; k++) begin
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    // Word storage; contents deliberately survive reset and clear.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (wr_en_s[k]) begin
                mem_q[k][wptr_q[k]] <= wr_word_s[k];
            end
        end
    end

    // Drive the bus outputs from registered state.
    always_comb begin
        bus.o_rd_valid = rd_valid_q;
        bus.o_rd_err   = rd_err_q;
        bus.o_rd_data  = rd_data_q;
        bus.o_rd_perr  = rd_perr_q;
        bus.o_overflow = ovf_q;
        for (int k = 0; k < N; k++) begin
            bus.o_count[k*CW +: CW] = cnt_q[k];
            bus.o_empty[k]          = (cnt_q[k] == {CW{1'b0}});
            bus.o_full[k]           = (cnt_q[k] == CW'(D));
        end
    end
endmodule

// File: tb/tb_uart_rx_capture_buffer.sv
// Bench for uart_rx_capture_buffer: drop-policy and overwrite-policy
// instances (2 channels, depth 4) plus a 3-channel instance for an
// out-of-range select. Read responses are checked through a scoreboard.
module tb_uart_rx_capture_buffer;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Cycle counter used for read-latency checking.
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_capture_buffer_if #(.G_NB_CHANNEL(2), .G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(2)) ifc0 ();
    uart_rx_capture_buffer_if #(.G_NB_CHANNEL(2), .G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(2)) ifc1 ();
    uart_rx_capture_buffer_if #(.G_NB_CHANNEL(3), .G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(2)) ifc2 ();

    uart_rx_capture_buffer #(.G_NB_CHANNEL(2), .G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(2), .G_OVERWRITE(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
    uart_rx_capture_buffer #(.G_NB_CHANNEL(2), .G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(2), .G_OVERWRITE(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
    uart_rx_capture_buffer #(.G_NB_CHANNEL(3), .G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(2), .G_OVERWRITE(0))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2.slave));

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        logic       perr;
        int         due;
    } exp_t;

    exp_t sbq [3][$];

    typedef struct {
        int         op;     // 0 = receive word, 1 = read
        int         ch;
        logic [7:0] d;
        logic       pe;
        logic       x_err;
        logic [7:0] x_d;
        logic       x_pe;
        int         x_c0;
        int         x_c1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int id, input logic xe, input logic [7:0] xd, input logic xp);
        exp_t e;
        e.is_err = xe;
        e.data   = xd;
        e.perr   = xp;
        e.due    = cyc + 1;
        sbq[id].push_back(e);
    endtask

    task automatic mon(input int id, input logic v, input logic e, input logic [7:0] d, input logic p);
        exp_t x;
        if (v || e) begin
            if (sbq[id].size() == 0) begin
                chk($sformatf("dut%0d_unexpected_rsp", id), 1, 0);
            end else begin
                x = sbq[id].pop_front();
                chk($sformatf("dut%0d_rsp_cycle", id), cyc, x.due);
                chk($sformatf("dut%0d_rsp_err", id), int'(e), int'(x.is_err));
                chk($sformatf("dut%0d_rsp_valid", id), int'(v), int'(!x.is_err));
                if (!x.is_err) begin
                    chk($sformatf("dut%0d_rsp_data", id), int'(d), int'(x.data));
                    chk($sformatf("dut%0d_rsp_perr", id), int'(p), int'(x.perr));
                end
            end
        end else if (sbq[id].size() != 0 && sbq[id][0].due <= cyc) begin
            x = sbq[id].pop_front();
            chk($sformatf("dut%0d_rsp_missing", id), 0, 1);
        end
    endtask

    // Scoreboard monitors, sampling away from the rising edge.
    always @(negedge clk) mon(0, ifc0.o_rd_valid, ifc0.o_rd_err, ifc0.o_rd_data, ifc0.o_rd_perr);
    always @(negedge clk) mon(1, ifc1.o_rd_valid, ifc1.o_rd_err, ifc1.o_rd_data, ifc1.o_rd_perr);
    always @(negedge clk) mon(2, ifc2.o_rd_valid, ifc2.o_rd_err, ifc2.o_rd_data, ifc2.o_rd_perr);

    // One received word on channel ch of the instances selected by m.
    task automatic rx(input logic [1:0] m, input int ch, input logic [7:0] d, input logic pe);
        @(negedge clk);
        if (m[0]) begin
            ifc0.i_rx_done[ch] = 1'b1; ifc0.i_rx_data[ch*8 +: 8] = d; ifc0.i_parity_err[ch] = pe;
        end
        if (m[1]) begin
            ifc1.i_rx_done[ch] = 1'b1; ifc1.i_rx_data[ch*8 +: 8] = d; ifc1.i_parity_err[ch] = pe;
        end
        @(negedge clk);
        ifc0.i_rx_done = 2'b00;
        ifc1.i_rx_done = 2'b00;
    endtask

    // Single read request on instance id, expectation pushed when driven.
    task automatic rd(input int id, input int ch, input logic xe, input logic [7:0] xd, input logic xp);
        @(negedge clk);
        push(id, xe, xd, xp);
        if (id == 0) begin
            ifc0.i_rd_req = 1'b1; ifc0.i_rd_sel = 1'(ch);
        end else if (id == 1) begin
            ifc1.i_rd_req = 1'b1; ifc1.i_rd_sel = 1'(ch);
        end else begin
            ifc2.i_rd_req = 1'b1; ifc2.i_rd_sel = 2'(ch);
        end
        @(negedge clk);
        ifc0.i_rd_req = 1'b0;
        ifc1.i_rd_req = 1'b0;
        ifc2.i_rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0};
        tbl[1] = '{0, 0, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 2, 0};
        tbl[2] = '{0, 0, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 3, 0};
        tbl[3] = '{1, 0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 2, 0};
        tbl[4] = '{1, 0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1, 0};
        tbl[5] = '{1, 0, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 0, 0};
        tbl[6] = '{1, 1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0};
        tbl[7] = '{1, 0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0};
        tbl[8] = '{0, 1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1};
        tbl[9] = '{1, 1, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 0, 0};

        rst_n = 1'b0;
        ifc0.i_rx_done = 2'b01; ifc0.i_rx_data = 16'h0000; ifc0.i_parity_err = 2'b00;
        ifc0.i_clr = 2'b00; ifc0.i_rd_req = 1'b0; ifc0.i_rd_sel = 1'b0;
        ifc1.i_rx_done = 2'b00; ifc1.i_rx_data = 16'h0000; ifc1.i_parity_err = 2'b00;
        ifc1.i_clr = 2'b00; ifc1.i_rd_req = 1'b0; ifc1.i_rd_sel = 1'b0;
        ifc2.i_rx_done = 3'b000; ifc2.i_rx_data = 24'h000000; ifc2.i_parity_err = 3'b000;
        ifc2.i_clr = 3'b000; ifc2.i_rd_req = 1'b0; ifc2.i_rd_sel = 2'b00;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_empty", int'(ifc0.o_empty), 3);
        chk("rst_full", int'(ifc0.o_full), 0);
        chk("rst_count", int'(ifc0.o_count), 0);
        chk("rst_ovf", int'(ifc0.o_overflow), 0);
        chk("rst_rd_valid", int'(ifc0.o_rd_valid), 0);
        chk("rst_rd_err", int'(ifc0.o_rd_err), 0);
        chk("rst_rd_data", int'(ifc0.o_rd_data), 0);

        // rx_done held high across reset release must not write.
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_done_cnt0", int'(ifc0.o_count[2:0]), 0);
        ifc0.i_rx_done = 2'b00;
        repeat (2) @(negedge clk);
        chk("held_done_fall_cnt0", int'(ifc0.o_count[2:0]), 0);

        // Basic FIFO order, parity flag, empty reads.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].op == 0) rx(2'b01, tbl[i].ch, tbl[i].d, tbl[i].pe);
            else rd(0, tbl[i].ch, tbl[i].x_err, tbl[i].x_d, tbl[i].x_pe);
            chk($sformatf("tbl%0d_cnt0", i), int'(ifc0.o_count[2:0]), tbl[i].x_c0);
            chk($sformatf("tbl%0d_cnt1", i), int'(ifc0.o_count[5:3]), tbl[i].x_c1);
        end

        // Five words into ch1 of both policies.
        for (int i = 0; i < 5; i++) rx(2'b11, 1, 8'(8'hA0 + i), 1'b0);
        chk("drop_full1", int'(ifc0.o_full[1]), 1);
        chk("drop_ovf1", int'(ifc0.o_overflow[1]), 1);
        chk("drop_cnt1", int'(ifc0.o_count[5:3]), 4);
        chk("ovw_full1", int'(ifc1.o_full[1]), 1);
        chk("ovw_ovf1", int'(ifc1.o_overflow[1]), 1);
        chk("ovw_cnt1", int'(ifc1.o_count[5:3]), 4);
        for (int i = 0; i < 4; i++) rd(0, 1, 1'b0, 8'(8'hA0 + i), 1'b0);
        rd(0, 1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) rd(1, 1, 1'b0, 8'(8'hA1 + i), 1'b0);
        rd(1, 1, 1'b1, 8'h00, 1'b0);
        chk("drop_ovf1_sticky", int'(ifc0.o_overflow[1]), 1);
        chk("ovw_ovf1_sticky", int'(ifc1.o_overflow[1]), 1);
        chk("drop_empty1", int'(ifc0.o_empty[1]), 1);

        // Full ch0 with simultaneous write and read.
        for (int i = 0; i < 4; i++) rx(2'b01, 0, 8'(8'hC0 + i), 1'(i));
        chk("v4_full_before", int'(ifc0.o_full[0]), 1);
        @(negedge clk);
        ifc0.i_rx_done[0] = 1'b1; ifc0.i_rx_data[7:0] = 8'hC4; ifc0.i_parity_err[0] = 1'b1;
        ifc0.i_rd_req = 1'b1; ifc0.i_rd_sel = 1'b0;
        push(0, 1'b0, 8'hC0, 1'b0);
        @(negedge clk);
        ifc0.i_rx_done = 2'b00; ifc0.i_rd_req = 1'b0;
        chk("v4_cnt0", int'(ifc0.o_count[2:0]), 4);
        chk("v4_ovf0", int'(ifc0.o_overflow[0]), 0);
        rd(0, 0, 1'b0, 8'hC1, 1'b1);
        rd(0, 0, 1'b0, 8'hC2, 1'b0);
        rd(0, 0, 1'b0, 8'hC3, 1'b1);
        rd(0, 0, 1'b0, 8'hC4, 1'b1);
        chk("v4_drained", int'(ifc0.o_count[2:0]), 0);

        // Out-of-range select on the 3-channel instance.
        rd(2, 3, 1'b1, 8'h00, 1'b0);

        // Clear beats a same-cycle write and read.
        rx(2'b01, 0, 8'hD0, 1'b0);
        rx(2'b01, 0, 8'hD1, 1'b0);
        chk("clr_cnt_before", int'(ifc0.o_count[2:0]), 2);
        @(negedge clk);
        ifc0.i_clr = 2'b01; ifc0.i_rx_done[0] = 1'b1; ifc0.i_rx_data[7:0] = 8'hD2;
        ifc0.i_rd_req = 1'b1; ifc0.i_rd_sel = 1'b0;
        push(0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        ifc0.i_clr = 2'b00; ifc0.i_rx_done = 2'b00; ifc0.i_rd_req = 1'b0;
        chk("clr_cnt0", int'(ifc0.o_count[2:0]), 0);
        chk("clr_empty0", int'(ifc0.o_empty[0]), 1);
        rd(0, 0, 1'b1, 8'h00, 1'b0);

        // Write to empty with same-cycle read: no bypass.
        @(negedge clk);
        ifc0.i_rx_done[0] = 1'b1; ifc0.i_rx_data[7:0] = 8'hE5; ifc0.i_parity_err[0] = 1'b1;
        ifc0.i_rd_req = 1'b1; ifc0.i_rd_sel = 1'b0;
        push(0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        ifc0.i_rx_done = 2'b00; ifc0.i_rd_req = 1'b0;
        chk("nobypass_cnt0", int'(ifc0.o_count[2:0]), 1);
        rd(0, 0, 1'b0, 8'hE5, 1'b1);

        // Clear drops the sticky overflow.
        @(negedge clk);
        ifc0.i_clr = 2'b10;
        @(negedge clk);
        ifc0.i_clr = 2'b00;
        chk("clr_ovf1", int'(ifc0.o_overflow[1]), 0);

        // Reset mid-operation with words buffered and a read in flight.
        rx(2'b01, 0, 8'hF0, 1'b0);
        rx(2'b01, 0, 8'hF1, 1'b0);
        chk("prerst_empty", int'(ifc0.o_empty), 2);
        @(negedge clk);
        ifc0.i_rd_req = 1'b1; ifc0.i_rd_sel = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ifc0.i_rd_req = 1'b0;
        #1;
        chk("midrst_empty", int'(ifc0.o_empty), 3);
        chk("midrst_cnt0", int'(ifc0.o_count[2:0]), 0);
        chk("midrst_rd_valid", int'(ifc0.o_rd_valid), 0);
        chk("midrst_ovf_ovw", int'(ifc1.o_overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, 0, 1'b1, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("dut%0d_sb_leftover", i), sbq[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_capture_buffer.md
UART_RX_CAPTURE_BUFFER -- requirements
Module: uart_rx_capture_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- G_NB_CHANNEL, 2, number of independent UART RX channels.
- G_DATA_WIDTH, 8, bits per received word.
- G_BUFFER_ADDR_WIDTH, 4, per-channel depth is 2**G_BUFFER_ADDR_WIDTH words.
- G_OVERWRITE, 0, full-buffer policy: 0 drops the new word, 1 overwrites the oldest word.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- i_rx_done, in, G_NB_CHANNEL, per-channel RX-done level from rx_uart instances.
- i_rx_data, in, G_NB_CHANNEL*G_DATA_WIDTH, per-channel RX word; channel k in bits [k*W +: W].
- i_parity_err, in, G_NB_CHANNEL, per-channel parity error, qualified by i_rx_done.
- i_clr, in, G_NB_CHANNEL, per-channel synchronous buffer clear.
- i_rd_req, in, 1, single-cycle read request.
- i_rd_sel, in, SELW = max(1, clog2(G_NB_CHANNEL)), channel to read.
- o_rd_valid, out, 1, one-cycle pulse: o_rd_data/o_rd_perr valid.
- o_rd_data, out, G_DATA_WIDTH, popped word.
- o_rd_perr, out, 1, parity flag stored with the popped word.
- o_rd_err, out, 1, one-cycle pulse: read of an empty or out-of-range channel.
- o_count, out, G_NB_CHANNEL*(G_BUFFER_ADDR_WIDTH+1), per-channel occupancy.
- o_empty / o_full, out, G_NB_CHANNEL each, per-channel occupancy == 0 / == depth.
- o_overflow, out, G_NB_CHANNEL, sticky per-channel overflow flag.

Function
REQ-003 Each channel SHALL own a circular buffer of depth D = 2**G_BUFFER_ADDR_WIDTH entries of G_DATA_WIDTH+1 bits (word + parity flag), with write pointer, read pointer and count register.
REQ-004 A write SHALL occur on the cycle a rising edge of i_rx_done[k] is detected (registered previous value low, current high). i_rx_data[k] and i_parity_err[k] SHALL be sampled that cycle. Level-high i_rx_done SHALL cause exactly one write.
REQ-005 Pointers SHALL wrap from D-1 to 0. Count SHALL range 0..D and never wrap.
REQ-006 A read SHALL be taken when i_rd_req=1. With i_rd_sel<G_NB_CHANNEL and count>0: the oldest entry is popped and o_rd_valid=1 with data on the next cycle (latency 1). Otherwise o_rd_err=1 on the next cycle, and no state changes.
REQ-007 Write and read to a non-full, non-empty channel in the same cycle SHALL both occur, with count unchanged.
REQ-008 On write to a full channel with a read of that channel in the same cycle, both SHALL occur and o_overflow SHALL NOT be set.
REQ-009 On write to a full channel without a same-cycle read, o_overflow[k] SHALL be set. With G_OVERWRITE=0 the word is dropped and state is unchanged. With G_OVERWRITE=1 the oldest entry is replaced, both pointers advance, and count stays D.
REQ-010 On write to an empty channel with a same-cycle read of it, the read SHALL report o_rd_err. The written word SHALL NOT bypass to the read.
REQ-011 i_clr[k]=1 SHALL zero pointers, count and o_overflow[k] at the next edge. This SHALL take priority over a same-cycle write or read of channel k. The read SHALL report o_rd_err. Buffer contents SHALL NOT be cleared.
REQ-012 o_count, o_empty and o_full SHALL be registered-state derived, reflecting the state after the last edge.
REQ-013 Channels SHALL be fully independent, except for the shared read port.

Reset
REQ-014 While rst_n=0, all pointers, counts, o_overflow, o_rd_valid, o_rd_err, o_rd_data and o_rd_perr SHALL be 0; o_empty SHALL be all ones and o_full all zeros. Storage contents are not reset.
REQ-015 The i_rx_done edge-detect registers SHALL reset to 1, so that i_rx_done held high across reset release produces no write.
REQ-016 Reset assertion mid-operation SHALL discard all buffered words and any pending read response.

Verification
REQ-017 Bench SHALL cover, with G_NB_CHANNEL=2, W=8, ADDR=2 (D=4), unless stated otherwise:
- V1: ch0 receives 0x11, 0x22, 0x33, then three reads of ch0 -> o_rd_data 0x11, 0x22, 0x33, each o_rd_valid one cycle after its request; o_count[0] ends at 0.
- V2: G_OVERWRITE=0, ch1 receives 5 words 0xA0..0xA4 -> o_full[1]=1, o_overflow[1]=1; reads return 0xA0..0xA3, then the 5th read gives o_rd_err.
- V3: G_OVERWRITE=1, same stimulus as V2 -> reads return 0xA1..0xA4, o_overflow[1]=1.
- V4: ch0 full with a simultaneous rx_done edge and read -> pops the oldest word, the new word is stored, count stays 4, o_overflow[0]=0.
- V5: i_rd_sel=3, or a read of empty ch1 -> o_rd_err pulse, no o_rd_valid; i_clr[0] with a same-cycle write -> o_count[0]=0.
- V6: i_rx_done[0] held high across rst_n release -> no write; rst_n pulsed low with 2 words buffered -> o_empty=2'b11 immediately.
